// File: rtl/ext_pkg.sv
// ----------------------------------------------------------------------------
// ext_pkg
// Shared definitions for the immediate-extension pipeline.
//   ext_mode_e : 2-bit extension mode type
//     EXT_ZERO  zero-fill the upper bits
//     EXT_SIGN  replicate the immediate's top bit
//     EXT_HIGH  place the immediate in the top bits, low bits zero
//     EXT_SHL2  sign-extend, then shift left by two
// ----------------------------------------------------------------------------
package ext_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_HIGH = 2'd2,
        EXT_SHL2 = 2'd3
    } ext_mode_e;

endpackage : ext_pkg

// File: rtl/ext_core.sv
// ----------------------------------------------------------------------------
// ext_core
// Purely combinational immediate extender.
// Parameters:
//   IN_W   immediate width
//   OUT_W  result width, must be at least IN_W+2 so that SHL2 keeps every bit
// Ports:
//   mode      extension mode (ext_mode_e)
//   data_in   IN_W-bit immediate
//   data_out  OUT_W-bit extended result
// ----------------------------------------------------------------------------
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  ext_mode_e          mode,
    input  logic [IN_W-1:0]    data_in,
    output logic [OUT_W-1:0]   data_out
);

    // SHL2 needs two spare bits above the sign-extended immediate.
    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("ext_core: OUT_W must be >= IN_W+2");
    end

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;

    // Both base extensions are formed once; the mode only picks or reshapes them.
    always_comb begin
        zext     = {{(OUT_W-IN_W){1'b0}}, data_in};
        sext     = {{(OUT_W-IN_W){data_in[IN_W-1]}}, data_in};
        data_out = zext;
        case (mode)
            EXT_ZERO: data_out = zext;
            EXT_SIGN: data_out = sext;
            EXT_HIGH: data_out = {data_in, {(OUT_W-IN_W){1'b0}}};
            EXT_SHL2: data_out = {sext[OUT_W-3:0], 2'b00};
            default:  data_out = zext;
        endcase
    end

endmodule : ext_core

// File: rtl/ext_pipe.sv
// ----------------------------------------------------------------------------
// ext_pipe
// One-cycle valid/ready pipeline stage wrapping ext_core. The immediate is
// extended before the storage register, so out_data/out_tag come straight
// from flops.
//
// Configuration macro: EXT_PIPE_SKID_EN
//   defined   : two-entry skid buffer, registered in_ready (no path from
//               out_ready to in_ready)
//   undefined : single entry, in_ready = !out_valid || out_ready
//
// Parameters: IN_W (immediate width), OUT_W (result width, >= IN_W+2),
//             TAG_W (sideband tag width)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous flush, drops every stored item
//   in_valid/in_ready    upstream handshake
//   in_data/in_mode      immediate and extension mode
//   in_tag               sideband tag, passed through unchanged
//   out_valid/out_ready  downstream handshake
//   out_data/out_tag     extended result and its tag
// ----------------------------------------------------------------------------
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    logic [OUT_W-1:0] ext_data;
    logic             in_fire;
    logic             out_fire;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode     (ext_mode_e'(in_mode)),
        .data_in  (in_data),
        .data_out (ext_data)
    );

    // Head entry: this is what the downstream sees.
    logic               head_valid_q;
    logic [OUT_W-1:0]   head_data_q;
    logic [TAG_W-1:0]   head_tag_q;

    assign out_valid = head_valid_q;
    assign out_data  = head_data_q;
    assign out_tag   = head_tag_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = head_valid_q && out_ready;

`ifdef EXT_PIPE_SKID_EN

    // Second entry catches an item accepted while the head is stalled.
    logic               skid_valid_q;
    logic [OUT_W-1:0]   skid_data_q;
    logic [TAG_W-1:0]   skid_tag_q;
    logic               ready_q;

    logic               head_valid_n;
    logic [OUT_W-1:0]   head_data_n;
    logic [TAG_W-1:0]   head_tag_n;
    logic               skid_valid_n;
    logic [OUT_W-1:0]   skid_data_n;
    logic [TAG_W-1:0]   skid_tag_n;

    // ready_q is a flop, so out_ready never reaches in_ready combinationally;
    // only flush gates it directly.
    assign in_ready = ready_q && !flush;

    // Retire first (skid moves up into head), then place the new item in
    // the first free slot, which keeps items in acceptance order.
    always_comb begin
        head_valid_n = head_valid_q;
        head_data_n  = head_data_q;
        head_tag_n   = head_tag_q;
        skid_valid_n = skid_valid_q;
        skid_data_n  = skid_data_q;
        skid_tag_n   = skid_tag_q;
        if (flush) begin
            head_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else begin
            if (out_fire) begin
                if (skid_valid_q) begin
                    head_data_n  = skid_data_q;
                    head_tag_n   = skid_tag_q;
                    skid_valid_n = 1'b0;
                end else begin
                    head_valid_n = 1'b0;
                end
            end
            if (in_fire) begin
                if (!head_valid_n) begin
                    head_valid_n = 1'b1;
                    head_data_n  = ext_data;
                    head_tag_n   = in_tag;
                end else begin
                    skid_valid_n = 1'b1;
                    skid_data_n  = ext_data;
                    skid_tag_n   = in_tag;
                end
            end
        end
    end

    // Storage registers; in_ready rises on the first edge out of reset
    // and stays high while the skid slot will be empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            ready_q      <= 1'b0;
        end else begin
            head_valid_q <= head_valid_n;
            head_data_q  <= head_data_n;
            head_tag_q   <= head_tag_n;
            skid_valid_q <= skid_valid_n;
            skid_data_q  <= skid_data_n;
            skid_tag_q   <= skid_tag_n;
            ready_q      <= !skid_valid_n;
        end
    end

`else

    // run_q holds in_ready low during reset and until the first edge after it.
    logic run_q;

    assign in_ready = run_q && !flush && (!head_valid_q || out_ready);

    // Single entry: a new item overwrites the head in the same cycle the old
    // one leaves, giving one item per cycle when downstream is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_tag_q   <= '0;
        end else begin
            run_q <= 1'b1;
            if (flush) begin
                head_valid_q <= 1'b0;
            end else if (in_fire) begin
                head_valid_q <= 1'b1;
                head_data_q  <= ext_data;
                head_tag_q   <= in_tag;
            end else if (out_fire) begin
                head_valid_q <= 1'b0;
            end
        end
    end

`endif

endmodule : ext_pipe

// File: tb/tb_ext_pipe.sv
// ----------------------------------------------------------------------------
// tb_ext_pipe
// Directed self-checking bench for ext_pipe. A default-width instance covers
// the modes, backpressure, flush and reset; an 8->16 instance covers the
// narrow configuration. Works with or without EXT_PIPE_SKID_EN.
// ----------------------------------------------------------------------------
module tb_ext_pipe;
    import ext_pkg::*;

`ifdef EXT_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    logic        n_in_valid = 1'b0;
    logic        n_in_ready;
    logic [7:0]  n_in_data = '0;
    logic [1:0]  n_in_mode = '0;
    logic [4:0]  n_in_tag = '0;
    logic        n_out_valid;
    logic        n_out_ready = 1'b0;
    logic [15:0] n_out_data;
    logic [4:0]  n_out_tag;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    ext_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut_n (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_data   (n_in_data),
        .in_mode   (n_in_mode),
        .in_tag    (n_in_tag),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_data  (n_out_data),
        .out_tag   (n_out_tag)
    );

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0)
            $display("[TB] FAIL reset_hold: valid=%b ready=%b data=%h tag=%h want 0/0/0/0",
                     out_valid, in_ready, out_data, out_tag);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0)
            $display("[TB] FAIL reset_release_no_edge: in_ready=%b want 0", in_ready);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || n_in_ready !== 1'b1)
            $display("[TB] FAIL reset_first_edge: in_ready=%b out_valid=%b n_in_ready=%b want 1/0/1",
                     in_ready, out_valid, n_in_ready);
        else passed++;
    endtask

    task automatic test_modes();
        logic [1:0]  mv [7];
        logic [15:0] md [7];
        logic [31:0] me [7];
        mv = '{EXT_SIGN, EXT_ZERO, EXT_HIGH, EXT_SHL2, EXT_SHL2, EXT_SIGN, EXT_SHL2};
        md = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h0003, 16'h7FFF, 16'h8000};
        me = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC,
               32'h0000000C, 32'h00007FFF, 32'hFFFE0000};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mode  = mv[i];
            in_data  = md[i];
            in_tag   = 5'(i + 1);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== me[i] || out_tag !== 5'(i + 1))
                $display("[TB] FAIL mode_vec%0d: valid=%b data=%h tag=%0d want 1 %h %0d",
                         i, out_valid, out_data, out_tag, me[i], i + 1);
            else passed++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0)
            $display("[TB] FAIL mode_drain: out_valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_narrow();
        logic [1:0]  mv [4];
        logic [7:0]  md [4];
        logic [15:0] me [4];
        mv = '{EXT_SIGN, EXT_HIGH, EXT_ZERO, EXT_SHL2};
        md = '{8'h80, 8'hAB, 8'h80, 8'h80};
        me = '{16'hFF80, 16'hAB00, 16'h0080, 16'hFE00};
        n_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_in_valid = 1'b1;
            n_in_mode  = mv[i];
            n_in_data  = md[i];
            n_in_tag   = 5'(20 + i);
            @(posedge clk); #1;
            checks++;
            if (n_out_valid !== 1'b1 || n_out_data !== me[i] || n_out_tag !== 5'(20 + i))
                $display("[TB] FAIL narrow_vec%0d: valid=%b data=%h tag=%0d want 1 %h %0d",
                         i, n_out_valid, n_out_data, n_out_tag, me[i], 20 + i);
            else passed++;
        end
        @(negedge clk);
        n_in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  am [3];
        logic [15:0] ad [3];
        logic [4:0]  at [3];
        logic [31:0] ae [3];
        int sent;
        int got;
        int cyc;
        am = '{EXT_ZERO, EXT_SIGN, EXT_HIGH};
        ad = '{16'h00A5, 16'hF00F, 16'h00C3};
        at = '{5'd3, 5'd7, 5'd11};
        ae = '{32'h000000A5, 32'hFFFFF00F, 32'h00C30000};
        sent = 0;
        got  = 0;
        // Stalled phase: check in_ready each cycle before the edge.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_mode   = am[sent];
            in_data   = ad[sent];
            in_tag    = at[sent];
            #1;
            checks++;
            if (in_ready !== ((c == 0) || (c == 1 && SKID)))
                $display("[TB] FAIL stall_ready_c%0d: in_ready=%b want %b",
                         c, in_ready, (c == 0) || (c == 1 && SKID));
            else passed++;
            if (in_ready) sent++;
            @(posedge clk);
        end
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== ae[0] || out_tag !== at[0])
            $display("[TB] FAIL stall_hold: valid=%b data=%h tag=%0d want 1 %h %0d",
                     out_valid, out_data, out_tag, ae[0], at[0]);
        else passed++;
        // Draining phase: keep offering remaining items, collect in order.
        cyc = 0;
        while (got < 3 && cyc < 20) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 3);
            if (sent < 3) begin
                in_mode = am[sent];
                in_data = ad[sent];
                in_tag  = at[sent];
            end
            #1;
            if (out_valid) begin
                checks++;
                if (out_data !== ae[got] || out_tag !== at[got])
                    $display("[TB] FAIL drain_item%0d: data=%h tag=%0d want %h %0d",
                             got, out_data, out_tag, ae[got], at[got]);
                else passed++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            cyc++;
        end
        checks++;
        if (got !== 3)
            $display("[TB] FAIL drain_count: got=%0d want 3", got);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = EXT_ZERO;
        in_data   = 16'h0D0D;
        in_tag    = 5'd5;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd5)
            $display("[TB] FAIL flush_load: valid=%b tag=%0d want 1 5", out_valid, out_tag);
        else passed++;
        @(negedge clk);
        flush   = 1'b1;
        in_data = 16'h0E0E;
        in_tag  = 5'd6;
        #1;
        checks++;
        if (in_ready !== 1'b0)
            $display("[TB] FAIL flush_ready: in_ready=%b want 0", in_ready);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0)
            $display("[TB] FAIL flush_clear: out_valid=%b want 0", out_valid);
        else passed++;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1)
            $display("[TB] FAIL flush_ready_after: in_ready=%b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000E0E || out_tag !== 5'd6)
            $display("[TB] FAIL flush_next_item: valid=%b data=%h tag=%0d want 1 00000e0e 6",
                     out_valid, out_data, out_tag);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0)
            $display("[TB] FAIL flush_drain: out_valid=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = EXT_SIGN;
        in_data   = 16'h9999;
        in_tag    = 5'd9;
        @(posedge clk);
        @(negedge clk);
        in_data = 16'h1111;
        in_tag  = 5'd10;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0)
            $display("[TB] FAIL async_reset: valid=%b ready=%b data=%h tag=%h want 0/0/0/0",
                     out_valid, in_ready, out_data, out_tag);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL reset_empty: valid=%b ready=%b want 0 1", out_valid, in_ready);
        else passed++;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = EXT_HIGH;
        in_data   = 16'hBEEF;
        in_tag    = 5'd17;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hBEEF0000 || out_tag !== 5'd17)
            $display("[TB] FAIL reset_resume: valid=%b data=%h tag=%0d want 1 beef0000 17",
                     out_valid, out_data, out_tag);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_narrow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_ext_pipe

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, extended output width; SHALL satisfy OUT_W >= IN_W+2 (elaboration error otherwise).
REQ-003 Parameter TAG_W, default 5, sideband tag width (destination register index).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous pipeline flush.
REQ-007 in_valid  input  1  upstream item present.
REQ-008 in_ready  output  1  block can accept the item.
REQ-009 in_data  input  IN_W  immediate field.
REQ-010 in_mode  input  2  extension mode.
REQ-011 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  OUT_W  extended result.
REQ-015 out_tag  output  TAG_W  tag of the presented result.

Function
REQ-016 Modes SHALL be: 0 ZERO (zero-fill upper bits), 1 SIGN (replicate in_data[IN_W-1]), 2 HIGH (in_data placed in bits [OUT_W-1:OUT_W-IN_W], low bits zero), 3 SHL2 (sign-extend, then shift left 2, low 2 bits zero, truncated to OUT_W).
REQ-017 Transfer on input SHALL occur when in_valid && in_ready at a rising edge; transfer on output SHALL occur when out_valid && out_ready.
REQ-018 Latency SHALL be exactly one cycle: an item accepted at edge N is visible on out_* after edge N with out_valid high.
REQ-019 Extension SHALL be computed before the storage register; out_data and out_tag SHALL come directly from registers.
REQ-020 Items SHALL leave in acceptance order; no item is dropped or duplicated except by flush or reset.
REQ-021 out_data, out_tag SHALL hold stable while out_valid && !out_ready.
REQ-022 Simultaneous input and output transfer with storage full SHALL be allowed (throughput one item per cycle).
REQ-023 flush SHALL clear all stored items at the edge; in_ready SHALL be low while flush is high, so a concurrent input is not accepted.
REQ-024 flush SHALL take priority over any concurrent input or output transfer; out_valid SHALL be low the cycle after flush.

Reset
REQ-025 While rst_n is low, out_valid SHALL be 0, in_ready SHALL be 0, and out_data and out_tag SHALL be 0, asynchronously.
REQ-026 in_ready SHALL go high on the first edge after rst_n deasserts; reset mid-transfer SHALL discard all stored items.

Configuration
REQ-027 Macro EXT_PIPE_SKID_EN SHALL select storage.
REQ-028 With EXT_PIPE_SKID_EN defined: two-entry skid buffer; in_ready SHALL be a registered signal, high when fewer than 2 entries, with no combinational path from out_ready.
REQ-029 Without it: single entry; in_ready SHALL be !out_valid || out_ready (combinational); behaviour otherwise identical.

Structure
REQ-030 Package ext_pkg SHALL hold the mode constants (EXT_ZERO, EXT_SIGN, EXT_HIGH, EXT_SHL2) and the 2-bit mode type.
REQ-031 Combinational sub-module ext_core (IN_W, OUT_W parameters, mode, data in, data out) SHALL implement REQ-016; ext_pipe SHALL add the storage and handshake around it.

Verification
REQ-032 SIGN, in_data 16'h8001, out_ready=1 -> out_data 32'hFFFF8001 one cycle later; ZERO same input -> 32'h00008001.
REQ-033 HIGH 16'h1234 -> 32'h12340000; SHL2 16'hFFFF -> 32'hFFFFFFFC; SHL2 16'h0003 -> 32'h0000000C.
REQ-034 out_ready=0 and three back-to-back items A, B, C: with skid, A and B accepted and in_ready low before C; without skid, only A accepted. Then out_ready=1 -> A, B, C out in order, tags intact.
REQ-035 One item held, in_valid high, flush pulsed for one cycle -> out_valid 0 next cycle, input not accepted, next item after flush passes normally.
REQ-036 rst_n low mid-stream, asynchronous to clk -> out_valid 0 immediately, buffer empty after release.
REQ-037 IN_W=8, OUT_W=16, SIGN 8'h80 -> 16'hFF80; HIGH 8'hAB -> 16'hAB00.
